// File: rtl/z80_bus_master.sv
// Z80 bus-cycle initiator: turns single transaction requests into T-state accurate
// MREQ/IORQ/RD/WR/M1/RFSH strobe sequences, one clk period per T-state.
module z80_bus_master #(
    parameter logic [7:0] REF_HI   = 8'h00,
    parameter int         WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,
    input  logic        wait_n,
    output logic [15:0] a,
    input  logic [7:0]  d_in,
    output logic [7:0]  d_out,
    output logic        d_oe,
    output logic        m1,
    output logic        mreq,
    output logic        iorq,
    output logic        rd,
    output logic        wr,
    output logic        rfsh
);

    // state | meaning
    // IDLE  | ready for a request
    // T1    | address phase (illegal ops pass through here with no strobes)
    // T2    | strobe phase, WAIT sampled for mem/M1
    // TWA   | automatic io wait state, WAIT sampled
    // TW    | inserted wait state, down-counter guards against a stuck WAIT
    // T3    | data phase (refresh phase for M1)
    // T4    | M1 refresh tail
    // DONE  | one-cycle response pulse
    typedef enum logic [2:0] {
        S_IDLE, S_T1, S_T2, S_TWA, S_TW, S_T3, S_T4, S_DONE
    } state_t;

    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  d_out;
        logic        d_oe;
        logic        m1;
        logic        mreq;
        logic        iorq;
        logic        rd;
        logic        wr;
        logic        rfsh;
    } bus_t;

    localparam logic [2:0] OP_MRD  = 3'd0;
    localparam logic [2:0] OP_MWR  = 3'd1;
    localparam logic [2:0] OP_IORD = 3'd2;
    localparam logic [2:0] OP_IOWR = 3'd3;
    localparam logic [2:0] OP_M1   = 3'd4;
    localparam logic [7:0] WMAX    = 8'(WAIT_MAX);

    state_t      state, state_nxt;
    logic [2:0]  op_q, op_cur;
    logic [15:0] addr_q, addr_cur;
    logic [7:0]  wdata_q, wdata_cur;
    logic [7:0]  wcnt, wcnt_nxt;
    logic [6:0]  r_q;
    logic [7:0]  m1_data;
    logic        accept, abort;
    bus_t        bus_nxt;

    // Pin values for a given state; registered so each pin has one flop.
    function automatic bus_t bus_of(input state_t st, input logic [2:0] op,
                                    input logic [15:0] addr, input logic [7:0] wd,
                                    input logic [6:0] r);
        bus_t b;
        logic addr_ph, io_ph, strobe_ph;
        b       = '0;
        b.m1    = 1'b1;
        b.mreq  = 1'b1;
        b.iorq  = 1'b1;
        b.rd    = 1'b1;
        b.wr    = 1'b1;
        b.rfsh  = 1'b1;
        addr_ph   = st inside {S_T1, S_T2, S_TW, S_T3};
        io_ph     = st inside {S_T1, S_T2, S_TWA, S_TW, S_T3};
        strobe_ph = st inside {S_T2, S_TWA, S_TW, S_T3};
        case (op)
            OP_MRD: if (addr_ph) begin
                b.a    = addr;
                b.mreq = 1'b0;
                b.rd   = 1'b0;
            end
            OP_MWR: if (addr_ph) begin
                b.a     = addr;
                b.mreq  = 1'b0;
                b.d_oe  = 1'b1;
                b.d_out = wd;
                b.wr    = (st == S_T1);
            end
            OP_IORD, OP_IOWR: if (io_ph) begin
                b.a    = addr;
                b.iorq = !strobe_ph;
                if (op == OP_IORD) begin
                    b.rd = !strobe_ph;
                end else begin
                    b.wr    = !strobe_ph;
                    b.d_oe  = 1'b1;
                    b.d_out = wd;
                end
            end
            OP_M1: begin
                if (st inside {S_T1, S_T2, S_TW}) begin
                    b.a    = addr;
                    b.m1   = 1'b0;
                    b.mreq = 1'b0;
                    b.rd   = 1'b0;
                end else if (st == S_T3) begin
                    b.a    = {REF_HI, 1'b0, r};
                    b.mreq = 1'b0;
                    b.rfsh = 1'b0;
                end else if (st == S_T4) begin
                    b.a    = {REF_HI, 1'b0, r};
                    b.rfsh = 1'b0;
                end
            end
            default: ;
        endcase
        return b;
    endfunction

    always_comb begin
        accept    = (state == S_IDLE) && req_valid;
        op_cur    = accept ? req_op    : op_q;
        addr_cur  = accept ? req_addr  : addr_q;
        wdata_cur = accept ? req_wdata : wdata_q;
        state_nxt = state;
        wcnt_nxt  = wcnt;
        abort     = 1'b0;
        case (state)
            S_IDLE: if (req_valid) state_nxt = S_T1;
            S_T1: begin
                if (op_q > OP_M1) begin
                    state_nxt = S_DONE;
                    abort     = 1'b1;
                end else begin
                    state_nxt = S_T2;
                end
            end
            S_T2: begin
                if (op_q == OP_IORD || op_q == OP_IOWR) begin
                    state_nxt = S_TWA;
                end else if (!wait_n) begin
                    state_nxt = S_TW;
                    wcnt_nxt  = WMAX;
                end else begin
                    state_nxt = S_T3;
                end
            end
            S_TWA: begin
                if (!wait_n) begin
                    state_nxt = S_TW;
                    wcnt_nxt  = WMAX;
                end else begin
                    state_nxt = S_T3;
                end
            end
            S_TW: begin
                if (wait_n) begin
                    state_nxt = S_T3;
                end else if (wcnt == 8'd1) begin
                    state_nxt = S_DONE;
                    abort     = 1'b1;
                end else begin
                    wcnt_nxt = wcnt - 8'd1;
                end
            end
            S_T3:    state_nxt = (op_q == OP_M1) ? S_T4 : S_DONE;
            S_T4:    state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        bus_nxt = bus_of(state_nxt, op_cur, addr_cur, wdata_cur, r_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            op_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wcnt      <= '0;
            r_q       <= '0;
            m1_data   <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            a         <= '0;
            d_out     <= '0;
            d_oe      <= 1'b0;
            m1        <= 1'b1;
            mreq      <= 1'b1;
            iorq      <= 1'b1;
            rd        <= 1'b1;
            wr        <= 1'b1;
            rfsh      <= 1'b1;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
            if (accept) begin
                op_q    <= req_op;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (state == S_T4) r_q <= r_q + 7'd1;
            // Opcode byte is taken on the last cycle before refresh begins.
            if (op_q == OP_M1 && (state == S_T2 || state == S_TW) && state_nxt == S_T3)
                m1_data <= d_in;
            req_ready <= (state_nxt == S_IDLE);
            rsp_valid <= (state_nxt == S_DONE);
            rsp_err   <= abort;
            rsp_rdata <= '0;
            if (state_nxt == S_DONE && !abort) begin
                if (op_q == OP_MRD || op_q == OP_IORD) rsp_rdata <= d_in;
                else if (op_q == OP_M1)                rsp_rdata <= m1_data;
            end
            a     <= bus_nxt.a;
            d_out <= bus_nxt.d_out;
            d_oe  <= bus_nxt.d_oe;
            m1    <= bus_nxt.m1;
            mreq  <= bus_nxt.mreq;
            iorq  <= bus_nxt.iorq;
            rd    <= bus_nxt.rd;
            wr    <= bus_nxt.wr;
            rfsh  <= bus_nxt.rfsh;
        end
    end

endmodule

// File: tb/tb_z80_bus_master.sv
// Scoreboard bench for z80_bus_master: each request pushes its expected per-cycle bus
// trace and response; a negedge monitor pops and compares.
module tb_z80_bus_master;
    localparam logic [7:0] REF_HI   = 8'h12;
    localparam int         WAIT_MAX = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready;
    logic [2:0]  req_op;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid, rsp_err;
    logic [7:0]  rsp_rdata;
    logic        wait_n;
    logic [15:0] a;
    logic [7:0]  d_in, d_out;
    logic        d_oe, m1, mreq, iorq, rd, wr, rfsh;

    always #5 clk = ~clk;

    z80_bus_master #(.REF_HI(REF_HI), .WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .wait_n(wait_n), .a(a), .d_in(d_in), .d_out(d_out), .d_oe(d_oe),
        .m1(m1), .mreq(mreq), .iorq(iorq), .rd(rd), .wr(wr), .rfsh(rfsh)
    );

    typedef enum int {P_T1, P_T2, P_TWA, P_TW, P_T3, P_T4, P_DONE} phase_t;
    // sig = {m1,mreq,iorq,rd,wr,rfsh,d_oe,req_ready,rsp_valid,rsp_err}
    typedef struct {
        logic [15:0] a;
        bit          a_chk;
        logic [7:0]  dout;
        logic [9:0]  sig;
    } cyc_t;
    typedef struct {
        logic [7:0] rdata;
        logic       err;
        int         lat;
        int         c_acc;
    } rsp_t;

    cyc_t       trace_q[$];
    rsp_t       rsp_q[$];
    int         n_vec = 0;
    int         n_bad = 0;
    int         cyc = 0;
    bit         mon_en = 1'b0;
    logic [6:0] r_model = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected pins for one T-state of a transaction, straight from the bus-cycle rules.
    function automatic cyc_t model(input logic [2:0] op, input logic [15:0] addr,
                                   input logic [7:0] wd, input phase_t ph, input bit err,
                                   input logic [6:0] r);
        cyc_t c;
        logic m1_e, mreq_e, iorq_e, rd_e, wr_e, rfsh_e, oe_e;
        bit addr_ph, strobe_ph;
        {m1_e, mreq_e, iorq_e, rd_e, wr_e, rfsh_e} = 6'b111111;
        oe_e      = 1'b0;
        c.a       = addr;
        c.a_chk   = 1'b0;
        c.dout    = wd;
        addr_ph   = ph inside {P_T1, P_T2, P_TWA, P_TW, P_T3};
        strobe_ph = ph inside {P_T2, P_TWA, P_TW, P_T3};
        case (op)
            3'd0: if (addr_ph) begin c.a_chk = 1; mreq_e = 0; rd_e = 0; end
            3'd1: if (addr_ph) begin c.a_chk = 1; mreq_e = 0; oe_e = 1; wr_e = !strobe_ph; end
            3'd2: if (addr_ph) begin c.a_chk = 1; iorq_e = !strobe_ph; rd_e = !strobe_ph; end
            3'd3: if (addr_ph) begin c.a_chk = 1; iorq_e = !strobe_ph; wr_e = !strobe_ph; oe_e = 1; end
            3'd4: begin
                if (ph inside {P_T1, P_T2, P_TW}) begin
                    c.a_chk = 1; m1_e = 0; mreq_e = 0; rd_e = 0;
                end else if (ph == P_T3 || ph == P_T4) begin
                    c.a = {REF_HI, 1'b0, r}; c.a_chk = 1; rfsh_e = 0;
                    mreq_e = (ph == P_T4);
                end
            end
            default: ;
        endcase
        c.sig = {m1_e, mreq_e, iorq_e, rd_e, wr_e, rfsh_e, oe_e, 1'b0,
                 ph == P_DONE, (ph == P_DONE) && err};
        return c;
    endfunction

    always @(negedge clk) begin : monitor
        cyc_t e;
        rsp_t r;
        if (mon_en) begin
            if (trace_q.size() > 0) begin
                e = trace_q.pop_front();
                check("ctl", 32'({m1, mreq, iorq, rd, wr, rfsh, d_oe, req_ready, rsp_valid, rsp_err}),
                      32'(e.sig));
                if (e.a_chk) check("addr", 32'(a), 32'(e.a));
                if (e.sig[3]) check("dout", 32'(d_out), 32'(e.dout));
            end else begin
                check("idle", 32'({m1, mreq, iorq, rd, wr, rfsh, d_oe, req_ready, rsp_valid, rsp_err}),
                      32'(10'b1111110100));
            end
            if (rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    check("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    r = rsp_q.pop_front();
                    check("rdata", 32'(rsp_rdata), 32'(r.rdata));
                    check("rsp_err", 32'(rsp_err), 32'(r.err));
                    check("latency", 32'(cyc - r.c_acc + 1), 32'(r.lat));
                end
            end
        end
    end

    task automatic run_txn(input logic [2:0] op, input logic [15:0] addr, input logic [7:0] wd,
                           input int nw, input bit tmo, input bit keep);
        phase_t     ph[$];
        logic [7:0] din[$];
        logic       wt[$];
        bit         legal, io, err, smp;
        logic [7:0] rexp;
        int         lat, guard, c_acc;
        rsp_t       rs;
        legal = (op <= 3'd4);
        io    = (op == 3'd2 || op == 3'd3);
        err   = !legal || tmo;
        ph.push_back(P_T1);
        if (legal) begin
            ph.push_back(P_T2);
            if (io) ph.push_back(P_TWA);
            if (tmo) begin
                repeat (WAIT_MAX) ph.push_back(P_TW);
            end else begin
                repeat (nw) ph.push_back(P_TW);
                ph.push_back(P_T3);
                if (op == 3'd4) ph.push_back(P_T4);
            end
        end
        ph.push_back(P_DONE);
        if (!legal)   lat = 2;
        else if (tmo) lat = (io ? 3 : 2) + WAIT_MAX + 1;
        else          lat = ((op == 3'd0 || op == 3'd1) ? 4 : 5) + nw;
        for (int i = 0; i < ph.size(); i++) begin
            din.push_back(8'($urandom));
            smp = legal && ((ph[i] == P_T2 && !io) || ph[i] == P_TWA || ph[i] == P_TW);
            if (smp) wt.push_back(tmo ? 1'b0 : (ph[i+1] != P_TW));
            else     wt.push_back(1'($urandom_range(0, 1)));
        end
        rexp = '0;
        if (!err) begin
            for (int i = 0; i < ph.size(); i++) begin
                if ((op == 3'd0 || op == 3'd2) && ph[i] == P_T3) rexp = din[i];
                if (op == 3'd4 && i + 1 < ph.size() && ph[i+1] == P_T3) rexp = din[i];
            end
        end
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        req_valid = 1'b1;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            check("req_ready_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (!keep) req_valid = 1'b0;
        c_acc = cyc;
        for (int i = 0; i < ph.size(); i++)
            trace_q.push_back(model(op, addr, wd, ph[i], err, r_model));
        rs.rdata = rexp;
        rs.err   = err;
        rs.lat   = lat;
        rs.c_acc = c_acc;
        rsp_q.push_back(rs);
        if (legal && op == 3'd4 && !tmo) r_model = r_model + 7'd1;
        for (int i = 0; i < ph.size(); i++) begin
            wait_n = wt[i];
            d_in   = din[i];
            if (i < ph.size() - 1) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [2:0] op;
        int         sel;
        rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
        wait_n = 1'b1; d_in = '0;
        #23;
        check("rst_ctl", 32'({m1, mreq, iorq, rd, wr, rfsh, d_oe, rsp_valid, rsp_err}), 32'(9'b111111000));
        check("rst_a", 32'(a), 32'd0);
        check("rst_dout", 32'(d_out), 32'd0);
        check("rst_rdata", 32'(rsp_rdata), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1 mon_en = 1'b1;
        repeat (2) @(negedge clk);

        // reset in the middle of a memory write
        mon_en = 1'b0;
        req_op = 3'd1; req_addr = 16'h1234; req_wdata = 8'h5a; req_valid = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #3;
        check("t2_pre", 32'({mreq, wr}), 32'd0);
        rst_n = 1'b0;
        #1;
        check("abort_strobes", 32'({m1, mreq, iorq, rd, wr, rfsh, d_oe}), 32'(7'b1111110));
        repeat (3) begin
            @(negedge clk);
            check("abort_norsp", 32'(rsp_valid), 32'd0);
        end
        rst_n = 1'b1;
        r_model = '0;
        @(posedge clk);
        #1 mon_en = 1'b1;

        run_txn(3'd0, 16'h4000, 8'h00, 0, 1'b0, 1'b0);
        run_txn(3'd3, 16'h0080, 8'h3c, 0, 1'b0, 1'b0);
        run_txn(3'd2, 16'h0010, 8'h00, 2, 1'b0, 1'b0);
        run_txn(3'd0, 16'h2222, 8'h00, 0, 1'b1, 1'b0);
        run_txn(3'd6, 16'hbeef, 8'h11, 0, 1'b0, 1'b0);
        run_txn(3'd1, 16'h8001, 8'hc3, 1, 1'b0, 1'b0);
        run_txn(3'd4, 16'h0100, 8'h00, 3, 1'b1, 1'b0);
        run_txn(3'd0, 16'h0001, 8'h00, 0, 1'b0, 1'b1);
        run_txn(3'd0, 16'h0002, 8'h00, 0, 1'b0, 1'b1);
        run_txn(3'd0, 16'h0003, 8'h00, 0, 1'b0, 1'b0);
        repeat (129) run_txn(3'd4, 16'h0000, 8'h00, 0, 1'b0, 1'b0);

        for (int k = 0; k < 200; k++) begin
            sel = $urandom_range(0, 15);
            op  = (sel < 13) ? 3'(sel % 5) : 3'(5 + sel - 13);
            run_txn(op, 16'($urandom), 8'($urandom), $urandom_range(0, 3),
                    (op <= 3'd4) && ($urandom_range(0, 15) == 0), 1'b0);
        end

        repeat (5) @(negedge clk);
        check("trace_drain", 32'(trace_q.size()), 32'd0);
        check("rsp_drain", 32'(rsp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
